scsi_cd_stub: RTL

- Parametrised successor to the fixed empty-drive responder on the SCSI-CD bridge.
- Decodes a small SCSI command set: TEST UNIT READY, REQUEST SENSE, INQUIRY, plus rejection of all other opcodes.
- Keeps a persistent sense register, honours allocation length, and paces data bytes at a configurable rate.
- Reports media presence from a live input, so the same block models either an empty or a loaded-but-unreadable drive.

---
 rtl/scsi_cd_stub.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/scsi_cd_stub.sv
// SCSI CD-ROM command responder: TEST UNIT READY, REQUEST SENSE, INQUIRY, reject others.
// Define SCSI_CD_STUB_UNIT_ATTN_EN to report unit attention after reset or a media change.
module scsi_cd_stub #(
    parameter int unsigned BYTE_GAP = 1,
    parameter int unsigned INQ_LEN  = 36,
    parameter logic [7:0]  DEV_TYPE = 8'h05
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        MEDIA_PRESENT,
    input  logic [95:0] COMMAND,
    input  logic        COMM_SEND,
    output logic        STAT_GET,
    output logic [7:0]  STATUS,
    output logic [7:0]  CD_DATA,
    output logic        CD_WR,
    output logic        BUSY
);
    localparam logic [7:0] OpReqSense = 8'h03;
    localparam logic [7:0] OpInquiry  = 8'h12;
    localparam logic [7:0] OpTur      = 8'h00;
    localparam logic [7:0] StGood     = 8'h00;
    localparam logic [7:0] StCheck    = 8'h02;
    localparam logic [5:0] InqLen     = 6'(INQ_LEN);
    localparam logic [7:0] InqAddLen  = 8'(INQ_LEN - 5);
    localparam logic [3:0] GapLast    = 4'((BYTE_GAP > 0) ? BYTE_GAP - 1 : 0);

    typedef enum logic [1:0] {StIdle, StXfer, StGap, StStat} state_e;
    state_e state_q, state_d;

    logic [5:0] cnt_q, len_q;
    logic [3:0] gap_q;
    logic       is_rs_q;
    logic [7:0] stat_pend_q;
    logic [3:0] key_q;
    logic [7:0] asc_q, ascq_q;

    logic       accept;
    logic [7:0] opcode, alloc;
    logic       dec_data, dec_rs, dec_set_sense;
    logic [5:0] dec_len;
    logic [7:0] dec_status, dec_asc;
    logic [3:0] dec_key;
    logic [7:0] byte_sel;
    logic       stat_get_d, wr_d, busy_d;
    logic [7:0] data_d, status_d;
    logic       unused_cmd;

    assign accept     = (state_q == StIdle) && COMM_SEND;
    assign opcode     = COMMAND[7:0];
    assign alloc      = COMMAND[39:32];
    assign unused_cmd = ^{COMMAND[95:40], COMMAND[31:8]};

`ifdef SCSI_CD_STUB_UNIT_ATTN_EN
    logic [2:0] mp_sync_q;
    logic [1:0] prime_q;
    logic       attn_q;
    logic       mp_edge;

    // Edges are ignored until the synchroniser has filled after reset.
    assign mp_edge = (prime_q == 2'd3) && (mp_sync_q[2] ^ mp_sync_q[1]);

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            mp_sync_q <= 3'b000;
            prime_q   <= 2'd0;
            attn_q    <= 1'b1;
        end else begin
            mp_sync_q <= {mp_sync_q[1:0], MEDIA_PRESENT};
            if (prime_q != 2'd3) prime_q <= prime_q + 2'd1;
            if (mp_edge) begin
                attn_q <= 1'b1;
            end else if (accept && opcode != OpReqSense && opcode != OpInquiry) begin
                attn_q <= 1'b0;
            end
        end
    end
`endif

    always_comb begin
        dec_data      = 1'b0;
        dec_rs        = 1'b0;
        dec_len       = 6'd0;
        dec_status    = StGood;
        dec_set_sense = 1'b0;
        dec_key       = 4'h0;
        dec_asc       = 8'h00;
        case (opcode)
            OpTur: begin
                if (!MEDIA_PRESENT) begin
                    dec_status    = StCheck;
                    dec_set_sense = 1'b1;
                    dec_key       = 4'h2;
                    dec_asc       = 8'h3A;
                end
            end
            OpReqSense: begin
                dec_rs   = 1'b1;
                dec_len  = (alloc > 8'd18) ? 6'd18 : alloc[5:0];
                dec_data = (dec_len != 6'd0);
            end
            OpInquiry: begin
                dec_len  = (alloc > 8'(INQ_LEN)) ? InqLen : alloc[5:0];
                dec_data = (dec_len != 6'd0);
            end
            default: begin
                dec_status    = StCheck;
                dec_set_sense = 1'b1;
                dec_key       = 4'h5;
                dec_asc       = 8'h20;
            end
        endcase
`ifdef SCSI_CD_STUB_UNIT_ATTN_EN
        if (attn_q && opcode != OpReqSense && opcode != OpInquiry) begin
            dec_data      = 1'b0;
            dec_len       = 6'd0;
            dec_status    = StCheck;
            dec_set_sense = 1'b1;
            dec_key       = 4'h6;
            dec_asc       = 8'h28;
        end
`endif
    end

    // State register plus command context and persistent sense.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q     <= StIdle;
            cnt_q       <= 6'd0;
            len_q       <= 6'd0;
            gap_q       <= 4'd0;
            is_rs_q     <= 1'b0;
            stat_pend_q <= StGood;
            key_q       <= 4'h0;
            asc_q       <= 8'h00;
            ascq_q      <= 8'h00;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q       <= 6'd0;
                len_q       <= dec_len;
                is_rs_q     <= dec_rs;
                stat_pend_q <= dec_status;
                if (dec_set_sense) begin
                    key_q  <= dec_key;
                    asc_q  <= dec_asc;
                    ascq_q <= 8'h00;
                end
            end
            if (state_q == StXfer) begin
                cnt_q <= cnt_q + 6'd1;
                gap_q <= 4'd0;
            end else if (state_q == StGap) begin
                gap_q <= gap_q + 4'd1;
            end
            if (state_q == StStat && is_rs_q) begin
                key_q  <= 4'h0;
                asc_q  <= 8'h00;
                ascq_q <= 8'h00;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (COMM_SEND) state_d = dec_data ? StXfer : StStat;
            StXfer: begin
                if (cnt_q + 6'd1 == len_q) state_d = StStat;
                else if (BYTE_GAP > 0)     state_d = StGap;
            end
            StGap:  if (gap_q == GapLast) state_d = StXfer;
            StStat: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        byte_sel = 8'h00;
        if (is_rs_q) begin
            case (cnt_q)
                6'd0:    byte_sel = 8'h70;
                6'd2:    byte_sel = {4'h0, key_q};
                6'd7:    byte_sel = 8'h0A;
                6'd12:   byte_sel = asc_q;
                6'd13:   byte_sel = ascq_q;
                default: byte_sel = 8'h00;
            endcase
        end else begin
            case (cnt_q)
                6'd0:    byte_sel = DEV_TYPE;
                6'd1:    byte_sel = 8'h80;
                6'd2:    byte_sel = 8'h02;
                6'd3:    byte_sel = 8'h02;
                6'd4:    byte_sel = InqAddLen;
                6'd5, 6'd6, 6'd7: byte_sel = 8'h00;
                default: byte_sel = 8'h20;
            endcase
        end
    end

    // Outputs are registered, so each lags the state that produces it by one cycle.
    always_comb begin
        wr_d       = (state_q == StXfer);
        stat_get_d = (state_q == StStat);
        data_d     = wr_d ? byte_sel : CD_DATA;
        status_d   = stat_get_d ? stat_pend_q : STATUS;
        busy_d     = BUSY;
        if (accept)     busy_d = 1'b1;
        if (stat_get_d) busy_d = 1'b0;
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            STAT_GET <= 1'b0;
            STATUS   <= 8'h00;
            CD_DATA  <= 8'h00;
            CD_WR    <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            STAT_GET <= stat_get_d;
            STATUS   <= status_d;
            CD_DATA  <= data_d;
            CD_WR    <= wr_d;
            BUSY     <= busy_d;
        end
    end

endmodule
